// File: rtl/hk_spi_pt_pkg.sv
// hk_spi_pt_pkg: shared state type and command/channel constants for the hk SPI pass-thru mux
package hk_spi_pt_pkg;
  typedef enum logic [1:0] {IDLE, CMD, PASS, IGNORE} state_t;
  localparam logic [3:0] CMD_PREFIX_DEF = 4'hC;
  localparam logic [3:0] CH_MGMT_FLASH = 4'd4;
  localparam logic [3:0] CH_USER = 4'd2;
endpackage

// File: rtl/hk_spi_sync_edge.sv
// hk_spi_sync_edge: N-stage synchroniser with rise/fall detection on the synchronised copy
module hk_spi_sync_edge #(
  parameter int STAGES = 2,
  parameter logic INIT = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);
  logic [STAGES-1:0] sync;
  logic prev;
  always_ff @(posedge clk)
    if (rst) begin
      sync <= {STAGES{INIT}};
      prev <= INIT;
    end else begin
      sync <= {sync[STAGES-2:0], d};
      prev <= sync[STAGES-1];
    end
  assign q = sync[STAGES-1];
  assign rise = q & ~prev;
  assign fall = ~q & prev;
endmodule

// File: rtl/hk_spi_passthru_mux.sv
// hk_spi_passthru_mux: decodes the hk SPI command byte and routes pass-thru transactions to one of NUM_CH targets
module hk_spi_passthru_mux
  import hk_spi_pt_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W = 16,
  parameter logic [3:0] CMD_PREFIX = CMD_PREFIX_DEF
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              hk_sck_i,
  input  logic              hk_csb_i,
  input  logic              hk_sdi_i,
  output logic              hk_sdo_o,
  output logic              hk_sdo_oe_o,
  output logic              hk_sel_o,
  input  logic [NUM_CH-1:0] ch_enable_i,
  output logic [NUM_CH-1:0] pt_csb_o,
  output logic [NUM_CH-1:0] pt_sck_o,
  output logic [NUM_CH-1:0] pt_mosi_o,
  input  logic [NUM_CH-1:0] pt_miso_i,
  output logic [3:0]        active_ch_o,
  output logic              busy_o,
  output logic [CNT_W-1:0]  xfer_count_o,
  output logic              err_o
);
  state_t state, state_nx;
  logic sck_s, sck_rise, sck_fall_unused, csb_s, csb_rise, csb_fall;
  logic [SYNC_STAGES-1:0] sdi_sync;
  logic sdi_s, sck_q, sdi_q, sdo_q, err_q, pass, decode, prefix_ok, ch_ok;
  logic [6:0] shift;
  logic [7:0] cmd;
  logic [2:0] bit_cnt;
  logic [3:0] ch;
  logic [CNT_W-1:0] byte_cnt, xfer_q;
  logic [15:0] en_pad, miso_pad;
  logic [NUM_CH-1:0] sel;

  hk_spi_sync_edge #(.STAGES(SYNC_STAGES), .INIT(1'b0)) u_sck (
    .clk(wb_clk_i), .rst(wb_rst_i), .d(hk_sck_i), .q(sck_s), .rise(sck_rise), .fall(sck_fall_unused)
  );
  hk_spi_sync_edge #(.STAGES(SYNC_STAGES), .INIT(1'b1)) u_csb (
    .clk(wb_clk_i), .rst(wb_rst_i), .d(hk_csb_i), .q(csb_s), .rise(csb_rise), .fall(csb_fall)
  );

  always_ff @(posedge wb_clk_i)
    sdi_sync <= wb_rst_i ? '0 : {sdi_sync[SYNC_STAGES-2:0], hk_sdi_i};

  assign sdi_s = sdi_sync[SYNC_STAGES-1];
  assign cmd = {shift, sdi_s};
  assign en_pad = 16'(ch_enable_i);
  assign miso_pad = 16'(pt_miso_i);
  assign prefix_ok = cmd[7:4] == CMD_PREFIX;
  assign ch_ok = ({1'b0, cmd[3:0]} < 5'(NUM_CH)) && en_pad[cmd[3:0]];
  assign decode = state == CMD && sck_rise && !csb_rise && bit_cnt == 3'd7;
  // synchronised CSB is high only on the csb_rise cycle while in PASS, so this releases the target that same cycle
  assign pass = state == PASS && !csb_s;

  always_ff @(posedge wb_clk_i)
    state <= wb_rst_i ? IDLE : state_nx;

  always_comb
    state_nx = csb_rise ? IDLE :
               (state == IDLE && csb_fall) ? CMD :
               decode ? ((prefix_ok && ch_ok) ? PASS : IGNORE) : state;

  always_ff @(posedge wb_clk_i)
    if (wb_rst_i) begin
      shift <= '0;
      bit_cnt <= '0;
      ch <= '0;
      byte_cnt <= '0;
      xfer_q <= '0;
      err_q <= 1'b0;
      sck_q <= 1'b0;
      sdi_q <= 1'b0;
      sdo_q <= 1'b0;
    end else begin
      sck_q <= sck_s;
      sdi_q <= sdi_s;
      sdo_q <= pass & miso_pad[ch];
      if (state == IDLE && csb_fall) begin
        shift <= '0;
        bit_cnt <= '0;
        byte_cnt <= '0;
      end else if (sck_rise && !csb_rise && (state == CMD || state == PASS)) begin
        shift <= cmd[6:0];
        bit_cnt <= bit_cnt + 3'd1;
        if (state == PASS && bit_cnt == 3'd7 && !(&byte_cnt)) byte_cnt <= byte_cnt + 1'b1;
      end
      if (decode && prefix_ok && ch_ok) ch <= cmd[3:0];
      if (decode && prefix_ok && !ch_ok) err_q <= 1'b1;
      if (csb_rise && state == PASS) xfer_q <= byte_cnt;
    end

  always_comb begin
    sel = pass ? NUM_CH'(1) << ch : '0;
    pt_csb_o = ~sel;
    pt_sck_o = sel & {NUM_CH{sck_q}};
    pt_mosi_o = sel & {NUM_CH{sdi_q}};
    hk_sdo_oe_o = pass;
    busy_o = pass;
    hk_sel_o = !pass;
    hk_sdo_o = sdo_q;
    active_ch_o = pass ? ch : 4'd0;
    xfer_count_o = xfer_q;
    err_o = err_q;
  end
endmodule

// File: tb/tb_hk_spi_passthru_mux.sv
// tb_hk_spi_passthru_mux: scoreboard bench driving hk SPI transactions against a flash model
module tb_hk_spi_passthru_mux;
  localparam int N = 8;
  logic clk = 0, rst = 1, hk_sck = 0, hk_csb = 1, hk_sdi = 0, clr = 0, mon_en = 0;
  logic [N-1:0] ch_en = 8'h04, miso;
  logic hk_sdo, oe, sel, busy, err, hk_sdo3, oe3, sel3, busy3, err3;
  logic [N-1:0] pt_csb, pt_sck, pt_mosi, pt_csb3, pt_sck3, pt_mosi3;
  logic [3:0] act, act3;
  logic [15:0] xcnt, xcnt3;
  logic [31:0] exp_q[$], txn_q[$];
  int n_cmp = 0, n_err = 0, mch = 2, r = 0;
  logic ps = 0, pc = 1, mbit = 0, busy_seen = 0, sel_seen = 0;
  logic [7:0] mosi_sr = 0, rx_cmd = 0, csb_seen = 0;
  logic [7:0] rom [8] = '{8'h6f, 8'h00, 8'h00, 8'h0b, 8'h93, 8'h01, 8'h00, 8'h00};

  always #5 clk = ~clk;

  hk_spi_passthru_mux #(.NUM_CH(N), .SYNC_STAGES(2)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .hk_sck_i(hk_sck), .hk_csb_i(hk_csb), .hk_sdi_i(hk_sdi),
    .hk_sdo_o(hk_sdo), .hk_sdo_oe_o(oe), .hk_sel_o(sel), .ch_enable_i(ch_en),
    .pt_csb_o(pt_csb), .pt_sck_o(pt_sck), .pt_mosi_o(pt_mosi), .pt_miso_i(miso),
    .active_ch_o(act), .busy_o(busy), .xfer_count_o(xcnt), .err_o(err)
  );
  hk_spi_passthru_mux #(.NUM_CH(N), .SYNC_STAGES(3)) dut3 (
    .wb_clk_i(clk), .wb_rst_i(rst), .hk_sck_i(hk_sck), .hk_csb_i(hk_csb), .hk_sdi_i(hk_sdi),
    .hk_sdo_o(hk_sdo3), .hk_sdo_oe_o(oe3), .hk_sel_o(sel3), .ch_enable_i(ch_en),
    .pt_csb_o(pt_csb3), .pt_sck_o(pt_sck3), .pt_mosi_o(pt_mosi3), .pt_miso_i(miso),
    .active_ch_o(act3), .busy_o(busy3), .xfer_count_o(xcnt3), .err_o(err3)
  );

  // flash model on channel mch: counts rises only after its CSB has been low a cycle, read data after 4 bytes
  always @(posedge clk) begin
    ps <= pt_sck[mch];
    pc <= pt_csb[mch];
    if (pt_csb[mch]) begin
      r <= 0;
      mbit <= 0;
    end else if (pt_sck[mch] && !ps && !pc) begin
      r <= r + 1;
      mosi_sr <= {mosi_sr[6:0], pt_mosi[mch]};
      if (r == 7) rx_cmd <= {mosi_sr[6:0], pt_mosi[mch]};
    end else if (!pt_sck[mch] && ps && !pc && r >= 32 && r < 96)
      mbit <= rom[(r - 32) / 8][7 - ((r - 32) % 8)];
  end

  always_comb begin
    miso = '1;
    miso[mch] = mbit;
  end

  always @(posedge clk)
    if (clr) begin
      csb_seen <= '0;
      busy_seen <= 0;
      sel_seen <= 0;
    end else begin
      csb_seen <= csb_seen | ~pt_csb;
      busy_seen <= busy_seen | busy;
      sel_seen <= sel_seen | ~sel;
    end

  task automatic chk(input string nm, input logic [31:0] act_v, input logic [31:0] exp_v);
    n_cmp++;
    if (act_v !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", nm, act_v, exp_v);
    end
  endtask

  task automatic xfer_bits(input logic [7:0] tx, input int n);
    for (int i = 7; i > 7 - n; i--) begin
      hk_sdi = tx[i];
      repeat (8) @(negedge clk);
      hk_sck = 1;
      repeat (8) @(negedge clk);
      hk_sck = 0;
    end
  endtask

  task automatic cs_low();
    hk_csb = 0;
    repeat (8) @(negedge clk);
  endtask

  task automatic cs_high();
    repeat (8) @(negedge clk);
    hk_csb = 1;
    repeat (16) @(negedge clk);
  endtask

  task automatic clear_seen();
    clr = 1;
    @(negedge clk);
    clr = 0;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_pt_csb"}, pt_csb, 8'hFF);
    chk({tag, "_pt_sck"}, pt_sck, 8'h00);
    chk({tag, "_pt_mosi"}, pt_mosi, 8'h00);
    chk({tag, "_sdo_oe_sel_busy_err"}, {hk_sdo, oe, sel, busy, err}, 5'b00100);
    chk({tag, "_active_ch"}, act, 0);
    chk({tag, "_xfer_count"}, xcnt, 0);
  endtask

  task automatic sdo_mon();
    logic [7:0] sr;
    int nb = 0;
    forever begin
      @(posedge hk_sck);
      if (mon_en) begin
        sr = {sr[6:0], hk_sdo};
        nb++;
        if (nb == 8) begin
          nb = 0;
          chk("sdo_byte", sr, exp_q.size() > 0 ? exp_q.pop_front() : 32'hDEAD);
        end
      end
    end
  endtask

  task automatic txn_mon();
    forever begin
      @(posedge hk_csb);
      repeat (4) @(negedge clk);
      chk("xfer_count", xcnt, txn_q.size() > 0 ? txn_q.pop_front() : 32'hDEAD);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  initial begin
    int d2, d3, da;
    repeat (4) @(negedge clk);
    chk_reset("reset");
    rst = 0;
    fork
      sdo_mon();
      txn_mon();
    join_none
    clear_seen();
    cs_low();
    xfer_bits(8'h40, 8);
    xfer_bits(8'h03, 8);
    txn_q.push_back(0);
    cs_high();
    chk("hk_rd_sel_low_seen", sel_seen, 0);
    chk("hk_rd_csb_low_seen", csb_seen, 8'h00);
    chk("hk_rd_busy_seen", busy_seen, 0);
    clear_seen();
    cs_low();
    xfer_bits(8'hC2, 8);
    chk("pass_busy_oe_sel", {busy, oe, sel}, 3'b110);
    chk("pass_active_ch", act, 2);
    chk("pass_pt_csb", pt_csb, 8'hFB);
    foreach (rom[i]) exp_q.push_back(rom[i]);
    xfer_bits(8'h03, 8);
    for (int i = 0; i < 3; i++) xfer_bits(8'h00, 8);
    mon_en = 1;
    for (int i = 0; i < 8; i++) xfer_bits(8'h00, 8);
    mon_en = 0;
    txn_q.push_back(12);
    cs_high();
    chk("rd_csb_low_seen", csb_seen, 8'h04);
    chk("rd_flash_cmd", rx_cmd, 8'h03);
    chk("rd_err", err, 0);
    cs_low();
    xfer_bits(8'hC3, 8);
    chk("dis_err", err, 1);
    chk("dis_busy", busy, 0);
    chk("dis_pt_csb", pt_csb, 8'hFF);
    xfer_bits(8'h00, 8);
    txn_q.push_back(12);
    cs_high();
    cs_low();
    xfer_bits(8'hC2, 8);
    xfer_bits(8'hA0, 4);
    txn_q.push_back(0);
    hk_csb = 1;
    da = 0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (pt_csb[2] && da == 0) da = k;
    end
    chk("abort_csb_latency_ok", da > 0 && da <= 4, 1);
    repeat (16) @(negedge clk);
    chk("abort_err_sticky", err, 1);
    cs_low();
    xfer_bits(8'hC2, 8);
    xfer_bits(8'h05, 8);
    txn_q.push_back(1);
    cs_high();
    chk("valid_err_sticky", err, 1);
    cs_low();
    xfer_bits(8'hC2, 8);
    xfer_bits(8'h03, 8);
    chk("pre_rst_busy", busy, 1);
    rst = 1;
    @(negedge clk);
    chk_reset("midrst");
    rst = 0;
    xfer_bits(8'h00, 8);
    txn_q.push_back(0);
    cs_high();
    ch_en = 8'h10;
    mch = 4;
    clear_seen();
    cs_low();
    xfer_bits(8'hC4, 8);
    chk("ch4_active_ch", act, 4);
    xfer_bits(8'hAA, 8);
    xfer_bits(8'h55, 8);
    txn_q.push_back(2);
    cs_high();
    chk("ch4_csb_low_seen", csb_seen, 8'h10);
    chk("ch4_flash_byte", rx_cmd, 8'hAA);
    clear_seen();
    cs_low();
    xfer_bits(8'hC5, 7);
    txn_q.push_back(2);
    cs_high();
    chk("midcmd_err", err, 0);
    chk("midcmd_busy_seen", busy_seen, 0);
    ch_en = 8'h04;
    mch = 2;
    cs_low();
    xfer_bits(8'hC2, 8);
    hk_sdi = 0;
    repeat (8) @(negedge clk);
    hk_sck = 1;
    d2 = 0;
    d3 = 0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (d2 == 0 && pt_sck[2]) d2 = k;
      if (d3 == 0 && pt_sck3[2]) d3 = k;
    end
    hk_sck = 0;
    xfer_bits(8'h00, 7);
    txn_q.push_back(1);
    cs_high();
    chk("sck_delay_sync2", d2, 3);
    chk("sck_delay_sync3", d3, 4);
    chk("sdo_queue_drained", exp_q.size(), 0);
    chk("txn_queue_drained", txn_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/hk_spi_passthru_mux.md
Name: hk_spi_passthru_mux

Overview:
- Multi-channel successor to the single-target housekeeping SPI pass-thru path.
- Monitors the housekeeping SPI pins (SCK/CSB/SDI/SDO) in the system clock domain and decodes the first command byte of each transaction.
- A pass-thru command routes the rest of the transaction to one of NUM_CH downstream SPI targets (management flash, user flash, further user devices).
- Any other command leaves the transaction with the normal housekeeping register logic.

Parameters:
- NUM_CH, 4: number of downstream pass-thru channels (1..16).
- SYNC_STAGES, 2: synchroniser depth on hk_sck_i/hk_csb_i/hk_sdi_i (>=2).
- CNT_W, 16: width of the transferred-byte counter.
- CMD_PREFIX, 4'hC: upper nibble identifying a pass-thru command.

Ports:
- wb_clk_i  in  1  system clock; hk SCK must be <= wb_clk_i/8.
- wb_rst_i  in  1  synchronous, active-high reset.
- hk_sck_i  in  1  housekeeping SPI clock, mode 0, asynchronous.
- hk_csb_i  in  1  housekeeping chip select, active low.
- hk_sdi_i  in  1  housekeeping MOSI.
- hk_sdo_o  out  1  MISO returned from the selected channel.
- hk_sdo_oe_o  out  1  high while in PASS; housekeeping SDO mux uses it.
- hk_sel_o  out  1  high when the housekeeping register logic owns the transaction.
- ch_enable_i  in  NUM_CH  per-channel enable mask.
- pt_csb_o  out  NUM_CH  downstream chip selects, active low.
- pt_sck_o  out  NUM_CH  downstream clocks.
- pt_mosi_o  out  NUM_CH  downstream MOSI (io0).
- pt_miso_i  in  NUM_CH  downstream MISO (io1).
- active_ch_o  out  4  channel currently in PASS.
- busy_o  out  1  high in PASS.
- xfer_count_o  out  CNT_W  pass-thru bytes in the last completed transaction (excludes command byte).
- err_o  out  1  sticky: pass-thru to a disabled or out-of-range channel; cleared by reset only.

Behaviour:
- Clock and reset: one clock, wb_clk_i. Reset is synchronous and active-high on wb_rst_i.
- Reset values:
  - pt_csb_o all 1; pt_sck_o and pt_mosi_o all 0.
  - hk_sdo_o 0, hk_sdo_oe_o 0, hk_sel_o 1, busy_o 0.
  - active_ch_o 0, xfer_count_o 0, err_o 0; state IDLE; synchroniser flops to idle levels (CSB=1).
- Synchronisation and edge detection:
  - All three hk inputs pass through SYNC_STAGES flops.
  - Edges are detected on the synchronised copies: sck_rise, sck_fall, csb_fall, csb_rise.
- State machine:
  - IDLE -> CMD on csb_fall. Shift register and bit counter cleared.
  - CMD: shift SDI on each sck_rise, MSB first.
    - On the 8th sck_rise, decode cmd[7:4]==CMD_PREFIX and ch=cmd[3:0].
    - ch<NUM_CH and ch_enable_i[ch]=1 -> PASS. Next cycle pt_csb_o[ch]=0, hk_sel_o=0, hk_sdo_oe_o=1, busy_o=1, active_ch_o=ch.
    - Prefix match but channel disabled or out of range -> IGNORE, err_o set.
    - Prefix mismatch -> IGNORE, hk_sel_o stays 1.
  - PASS:
    - pt_sck_o[ch] = registered synchronised SCK; pt_mosi_o[ch] = registered synchronised SDI. Latency from pin to downstream pin is SYNC_STAGES+1 cycles; SCK and MOSI are equally delayed.
    - hk_sdo_o = pt_miso_i[ch], registered (1 cycle).
    - Non-selected channels held idle: csb 1, sck 0, mosi 0.
    - Byte counter increments every 8th sck_rise in PASS and saturates at all-ones.
  - IGNORE: all downstream outputs idle.
  - Any state: csb_rise -> IDLE next cycle.
    - Same cycle: pt_csb_o all 1, pt_sck_o all 0, busy_o 0, hk_sdo_oe_o 0, hk_sel_o 1.
    - If leaving PASS, xfer_count_o <= byte counter. Leaving CMD or IGNORE leaves xfer_count_o unchanged.
- Boundary conditions:
  - CSB deasserted mid-command byte: IDLE, no decode, err_o unchanged.
  - ch_enable_i is sampled only at decode. Clearing it mid-PASS does not abort the transaction.
  - csb_rise and sck_rise detected in the same cycle: csb_rise wins, and the edge is not counted.
  - wb_rst_i mid-PASS: all outputs return to reset values in the next cycle; the downstream device sees CSB rise.

Decomposition:
- Package hk_spi_pt_pkg holds:
  - state enum (IDLE, CMD, PASS, IGNORE);
  - CMD_PREFIX default;
  - channel-code constants: CH_MGMT_FLASH=4, CH_USER=2 (legacy 0xC4/0xC2 compatible).
- One sub-module, hk_spi_sync_edge: N-stage synchroniser plus rise/fall detect, instantiated for SCK and CSB; SDI uses the synchroniser only.

Test Plan:
- Reset, then send 0x40,0x03 (housekeeping read), CSB high -> hk_sel_o stays 1; pt_csb_o all 1; busy_o never 1; xfer_count_o stays 0.
- ch_enable_i=4'b0100, send 0xC2,0x03,0x00,0x00,0x00, then 8 read bytes with a flash model holding 6f 00 00 0b 93 01 00 00 on channel 2:
  - SDO returns 0x6f,0x00,0x00,0x0b,0x93,0x01,0x00,0x00;
  - only pt_csb_o[2] goes low;
  - xfer_count_o=12 after CSB rise.
- Send 0xC3 with ch_enable_i[3]=0 -> IGNORE; err_o=1 and stays 1 through later valid transactions until wb_rst_i.
- Send 0xC2 then raise CSB after 4 bits of the next byte -> pt_csb_o[2] high within SYNC_STAGES+2 cycles; xfer_count_o=0.
- Assert wb_rst_i for 1 cycle mid-PASS -> next cycle all outputs at reset values; the following 0xC4 transaction works on channel 4 (NUM_CH=8).
- Measure pin-to-pin delay of hk_sck_i to pt_sck_o[ch] -> exactly SYNC_STAGES+1 cycles for SYNC_STAGES=2 and 3.
